serial_addsub_digit: RTL and testbench

Parametrised digit-serial adder/subtractor. It processes operands of DIGIT_W*NUM_DIGITS bits as a framed stream of DIGIT_W-bit digits, least-significant digit first. Carry is chained between digits, and the add/subtract mode is selected once per frame. It reports final carry and signed overflow on the last digit. It is the multi-bit, framed successor to the 1-bit serial adder in the sequential-basics set.

---
 rtl/serial_addsub_digit.sv | 121 ++++++++++++
 tb/tb_serial_addsub_digit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor: LSD-first frames, carry chained between digits, mode per frame.
// Latency 1 cycle from accepted digit to out_valid. No backpressure: one digit per cycle is always accepted.
module serial_addsub_digit #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_sub,
  input  logic [DIGIT_W-1:0] in_a,
  input  logic [DIGIT_W-1:0] in_b,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic               out_carry,
  output logic               out_overflow,
  output logic               out_abort
);

  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic               valid_q, valid_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               last_q, last_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               abort_q, abort_d;

  logic               accept;
  logic               mode_eff;
  logic               cin;
  logic               c_msb;
  logic               is_last;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   sum;
  logic [CW-1:0]      cnt_eff;

  // Digits outside a frame (IDLE without in_first) are silently dropped.
  assign accept   = in_valid & (in_first | (state_q == S_RUN));
  assign mode_eff = in_first ? in_sub : mode_q;
  assign b_eff    = in_b ^ {DIGIT_W{mode_eff}};
  assign cin      = in_first ? in_sub : carry_q;
  assign sum      = {1'b0, in_a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
  // Carry into the digit MSB recovered from the MSB sum bit; reduces to cin when DIGIT_W==1.
  assign c_msb    = sum[DIGIT_W-1] ^ in_a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];
  assign cnt_eff  = in_first ? '0 : cnt_q;
  assign is_last  = (cnt_eff == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    valid_d = accept;
    digit_d = digit_q;
    last_d  = 1'b0;
    cout_d  = 1'b0;
    ovf_d   = 1'b0;
    abort_d = 1'b0;
    if (accept) begin
      carry_d = sum[DIGIT_W];
      mode_d  = mode_eff;
      digit_d = sum[DIGIT_W-1:0];
      abort_d = in_first & (state_q == S_RUN);
      if (is_last) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        last_d  = 1'b1;
        cout_d  = sum[DIGIT_W];
        ovf_d   = c_msb ^ sum[DIGIT_W];
      end else begin
        state_d = S_RUN;
        cnt_d   = cnt_eff + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      digit_q <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      digit_q <= digit_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_digit    = digit_q;
  assign out_last     = last_q;
  assign out_carry    = cout_q;
  assign out_overflow = ovf_q;
  assign out_abort    = abort_q;

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Bench for serial_addsub_digit: 4x4 and 1x8 instances checked against a whole-word arithmetic model via scoreboard queues.
module tb_serial_addsub_digit;

  typedef struct packed {
    logic [3:0] dig;
    logic       last;
    logic       carry;
    logic       ovf;
    logic       abort;
  } exp_t;

  logic clk, rst_n;
  logic v4, f4, s4;
  logic [3:0] a4, b4;
  logic v1, f1, s1;
  logic [0:0] a1, b1;

  logic       o4_valid, o4_last, o4_carry, o4_ovf, o4_abort;
  logic [3:0] o4_digit;
  logic       o1_valid, o1_last, o1_carry, o1_ovf, o1_abort;
  logic [0:0] o1_digit;

  exp_t q4[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  serial_addsub_digit #(.DIGIT_W(4), .NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst_n), .in_valid(v4), .in_first(f4), .in_sub(s4),
    .in_a(a4), .in_b(b4), .out_valid(o4_valid), .out_digit(o4_digit),
    .out_last(o4_last), .out_carry(o4_carry), .out_overflow(o4_ovf), .out_abort(o4_abort)
  );

  serial_addsub_digit #(.DIGIT_W(1), .NUM_DIGITS(8)) dut1 (
    .clk(clk), .rst(rst_n), .in_valid(v1), .in_first(f1), .in_sub(s1),
    .in_a(a1), .in_b(b1), .out_valid(o1_valid), .out_digit(o1_digit),
    .out_last(o1_last), .out_carry(o1_carry), .out_overflow(o1_ovf), .out_abort(o1_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Advance one clock and compare both instances against their scoreboards.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("w4_valid", {31'd0, o4_valid}, 32'd1);
      chk("w4_digit", {28'd0, o4_digit}, {28'd0, e.dig});
      chk("w4_last",  {31'd0, o4_last},  {31'd0, e.last});
      chk("w4_carry", {31'd0, o4_carry}, {31'd0, e.carry});
      chk("w4_ovf",   {31'd0, o4_ovf},   {31'd0, e.ovf});
      chk("w4_abort", {31'd0, o4_abort}, {31'd0, e.abort});
    end else begin
      chk("w4_idle_valid", {31'd0, o4_valid}, 32'd0);
      chk("w4_idle_flags", {28'd0, o4_last, o4_carry, o4_ovf, o4_abort}, 32'd0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("w1_valid", {31'd0, o1_valid}, 32'd1);
      chk("w1_digit", {31'd0, o1_digit}, {28'd0, e.dig});
      chk("w1_last",  {31'd0, o1_last},  {31'd0, e.last});
      chk("w1_carry", {31'd0, o1_carry}, {31'd0, e.carry});
      chk("w1_ovf",   {31'd0, o1_ovf},   {31'd0, e.ovf});
      chk("w1_abort", {31'd0, o1_abort}, {31'd0, e.abort});
    end else begin
      chk("w1_idle_valid", {31'd0, o1_valid}, 32'd0);
      chk("w1_idle_flags", {28'd0, o1_last, o1_carry, o1_ovf, o1_abort}, 32'd0);
    end
  endtask

  // Drive ndig digits of one frame; expected digits come from whole-word arithmetic.
  task automatic send_frame(input bit sel, input logic [15:0] a, input logic [15:0] b,
                            input bit sub, input int bmax, input int ndig, input bit ab);
    int w, n, tot;
    logic [31:0] m, dm, ra, rb, rr, da, db;
    logic cy, ov, sa, sb, sr;
    exp_t e;
    w   = sel ? 1 : 4;
    n   = sel ? 8 : 4;
    tot = w * n;
    m   = (32'd1 << tot) - 32'd1;
    dm  = (32'd1 << w) - 32'd1;
    ra  = {16'd0, a} & m;
    rb  = {16'd0, b} & m;
    if (sub) begin
      rr = (ra - rb) & m;
      cy = (ra >= rb);
    end else begin
      rr = (ra + rb) & m;
      cy = ((ra + rb) >> tot) != 32'd0;
    end
    sa = ra[tot-1];
    sb = rb[tot-1];
    sr = rr[tot-1];
    ov = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    for (int i = 0; i < ndig; i++) begin
      da      = (ra >> (i * w)) & dm;
      db      = (rb >> (i * w)) & dm;
      e.dig   = 4'((rr >> (i * w)) & dm);
      e.last  = (i == n - 1);
      e.carry = e.last ? cy : 1'b0;
      e.ovf   = e.last ? ov : 1'b0;
      e.abort = (i == 0) ? ab : 1'b0;
      if (sel) begin
        v1 = 1'b1; f1 = (i == 0); s1 = sub; a1 = da[0:0]; b1 = db[0:0];
        q1.push_back(e);
      end else begin
        v4 = 1'b1; f4 = (i == 0); s4 = sub; a4 = da[3:0]; b4 = db[3:0];
        q4.push_back(e);
      end
      step();
      v4 = 1'b0; v1 = 1'b0; f4 = 1'b0; f1 = 1'b0;
      s4 = ~s4; s1 = ~s1;
      if (i < ndig - 1) begin
        int nb;
        nb = $urandom_range(0, bmax);
        for (int k = 0; k < nb; k++) step();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v4 = 0; f4 = 0; s4 = 0; a4 = 0; b4 = 0;
    v1 = 0; f1 = 0; s1 = 0; a1 = 0; b1 = 0;
    #2;
    chk("reset_valid", {31'd0, o4_valid}, 32'd0);
    chk("reset_outs", {24'd0, o4_digit, o4_last, o4_carry, o4_ovf, o4_abort}, 32'd0);
    #10 rst_n = 1'b1;

    // Plain add/sub cases and sign/carry boundaries.
    send_frame(0, 16'h1234, 16'h0FFF, 0, 0, 4, 0);
    send_frame(0, 16'h0005, 16'h0007, 1, 0, 4, 0);
    send_frame(0, 16'h0007, 16'h0005, 1, 0, 4, 0);
    send_frame(0, 16'h7FFF, 16'h0001, 0, 0, 4, 0);
    send_frame(0, 16'hFFFF, 16'h0001, 0, 0, 4, 0);
    step();

    // Bubbles between digits, then an immediate back-to-back frame.
    send_frame(0, 16'h1234, 16'h0FFF, 0, 3, 4, 0);
    send_frame(0, 16'h8000, 16'h0001, 1, 0, 4, 0);
    step();

    // Abandoned frame followed by a fresh digit 0.
    send_frame(0, 16'h1234, 16'h0FFF, 0, 0, 2, 0);
    send_frame(0, 16'h7FFF, 16'h0001, 0, 0, 4, 1);

    // Stray non-first digit while idle produces nothing.
    v4 = 1'b1; f4 = 1'b0; a4 = 4'h5; b4 = 4'h3;
    step();
    v4 = 1'b0;
    step();

    // Asynchronous reset mid-frame.
    send_frame(0, 16'h1234, 16'h0FFF, 0, 0, 2, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, o4_valid}, 32'd0);
    chk("async_rst_outs", {24'd0, o4_digit, o4_last, o4_carry, o4_ovf, o4_abort}, 32'd0);
    #10 rst_n = 1'b1;
    v4 = 1'b1; f4 = 1'b0; a4 = 4'h3; b4 = 4'hF;
    step();
    v4 = 1'b0;
    send_frame(0, 16'hABCD, 16'h1111, 1, 2, 4, 0);
    step();

    // Bit-serial instance.
    send_frame(1, 16'h007F, 16'h0001, 0, 0, 8, 0);
    send_frame(1, 16'h0003, 16'h0005, 1, 2, 8, 0);
    step();

    for (int r = 0; r < 6; r++) begin
      send_frame(0, 16'($urandom), 16'($urandom), 1'($urandom), 2, 4, 0);
    end
    step();
    chk("q4_drained", q4.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
